// File: rtl/vram_arbiter.sv
// Shares one synchronous-read VRAM port between the pixel generator and a host.
// The pixel fetcher always wins; the host gets a one-cycle issue slot when the port is free.
module vram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              px_active,
   input  logic [1:0]        px_phase,
   input  logic [ADDR_W-1:0] px_addr,
   output logic [DATA_W-1:0] px_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       wait_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      ACK
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [15:0]       r_waitCnt;
   logic              w_pxSlot;
   logic              w_issue;
   logic              w_wait;

   // Phase 3 is the pixel generator's staging phase, the only time it leaves the port alone.
   assign w_pxSlot = px_active && (px_phase != 2'd3);
   // rst_n gates the issue so no write can strobe the memory while reset is held.
   assign w_issue  = rst_n && (r_state == IDLE) && cpu_req && !w_pxSlot;
   assign w_wait   = (r_state == IDLE) && cpu_req && w_pxSlot;

   assign px_rdata  = mem_rdata;
   assign cpu_rdata = r_rdata;
   assign wait_cnt  = r_waitCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      cpu_ack   = 1'b0;
      mem_addr  = px_addr;
      mem_we    = 1'b0;
      mem_wdata = r_wdata;
      case (r_state)
         IDLE: begin
            if (w_issue) begin
               mem_addr  = cpu_addr;
               mem_we    = cpu_we;
               mem_wdata = cpu_wdata;
               w_next    = cpu_we ? ACK : RD_WAIT;
            end
         end
         RD_WAIT: w_next = ACK;
         ACK: begin
            cpu_ack = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else if (w_issue) begin
         r_we    <= cpu_we;
         r_wdata <= cpu_wdata;
      end
   end

   // The read word lands one cycle after issue; capture it so it stays put until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if ((r_state == RD_WAIT) && !r_we) begin
         r_rdata <= mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt <= 16'd0;
      end else if (w_wait && (r_waitCnt != 16'hFFFF)) begin
         r_waitCnt <= r_waitCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural host model, synchronous VRAM model,
// and a scoreboard of expected host read data popped on every cpu_ack.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        px_active;
   logic [1:0]  px_phase;
   logic [13:0] px_addr;
   logic [15:0] px_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic [13:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [15:0] wait_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] memArr [0:16383];
   logic [15:0] refMem [0:16383];
   logic        memReady = 1'b0;
   logic [15:0] expQ [$];

   int          hState;
   logic        hWe;
   logic [13:0] hAddr;
   logic [15:0] hData;
   int          remain;
   logic [15:0] expWait;
   logic [15:0] lastRead;

   vram_arbiter #(.ADDR_W(14), .DATA_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .px_active (px_active),
      .px_phase  (px_phase),
      .px_addr   (px_addr),
      .px_rdata  (px_rdata),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .wait_cnt  (wait_cnt)
   );

   always #5 clk = ~clk;

   // Single-port synchronous-read VRAM; clears itself on the first clock.
   always @(posedge clk) begin
      if (!memReady) begin
         for (int i = 0; i < 16384; i++) memArr[i] <= 16'h0000;
         memReady <= 1'b1;
      end else begin
         if (mem_we) memArr[mem_addr] <= mem_wdata;
         mem_rdata <= memArr[mem_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      expQ.delete();
      hState   = 0;
      remain   = 0;
      expWait  = 16'h0000;
      lastRead = 16'h0000;
   endtask

   // One clock cycle: drive at the falling edge, then check the cycle's outputs against the host model.
   task automatic applyStimulus(input logic act, input logic [1:0] ph, input logic [13:0] pa,
                                input logic newReq, input logic we, input logic [13:0] addr,
                                input logic [15:0] data);
      logic ackNow;
      logic slot;
      @(negedge clk);
      ackNow = 1'b0;
      if (hState == 2) begin
         remain--;
         if (remain == 0) begin
            ackNow  = 1'b1;
            hState  = 0;
            cpu_req = 1'b0;
         end
      end
      px_active = act;
      px_phase  = ph;
      px_addr   = pa;
      if (!ackNow && hState == 0 && newReq) begin
         cpu_req   = 1'b1;
         cpu_we    = we;
         cpu_addr  = addr;
         cpu_wdata = data;
         hWe       = we;
         hAddr     = addr;
         hData     = data;
         hState    = 1;
      end
      #1;
      checkOutput("cpu_ack", {31'd0, cpu_ack}, {31'd0, ackNow});
      if (cpu_ack === 1'b1) begin
         if (expQ.size() == 0) checkOutput("ack_without_request", {31'd0, cpu_ack}, 32'd0);
         else checkOutput("ack_rdata", {16'd0, cpu_rdata}, {16'd0, expQ.pop_front()});
      end
      checkOutput("wait_cnt", {16'd0, wait_cnt}, {16'd0, expWait});
      checkOutput("px_rdata", {16'd0, px_rdata}, {16'd0, mem_rdata});
      slot = act && (ph != 2'd3);
      if (hState == 1 && !slot) begin
         checkOutput("issue_we", {31'd0, mem_we}, {31'd0, hWe});
         checkOutput("issue_addr", {18'd0, mem_addr}, {18'd0, hAddr});
         if (hWe) begin
            checkOutput("issue_wdata", {16'd0, mem_wdata}, {16'd0, hData});
            refMem[hAddr] = hData;
            expQ.push_back(lastRead);
            remain = 1;
         end else begin
            lastRead = refMem[hAddr];
            expQ.push_back(lastRead);
            remain = 2;
         end
         hState = 2;
      end else begin
         checkOutput("idle_we", {31'd0, mem_we}, 32'd0);
         checkOutput("idle_addr", {18'd0, mem_addr}, {18'd0, pa});
         if (hState == 1 && expWait != 16'hFFFF) expWait = expWait + 16'd1;
      end
   endtask

   initial begin
      int weSeen;
      int ackSeen;
      int addrBad;
      for (int i = 0; i < 16384; i++) refMem[i] = 16'h0000;
      rst_n     = 1'b0;
      px_active = 1'b0;
      px_phase  = 2'd0;
      px_addr   = 14'h0000;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 14'h0000;
      cpu_wdata = 16'h0000;
      hWe       = 1'b0;
      hAddr     = 14'h0000;
      hData     = 16'h0000;
      resetModel();

      repeat (3) @(negedge clk);
      cpu_req = 1'b1;
      cpu_we  = 1'b1;
      #1;
      checkOutput("rst_ack", {31'd0, cpu_ack}, 32'd0);
      checkOutput("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
      checkOutput("rst_wait", {16'd0, wait_cnt}, 32'd0);
      checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1 and 2: no pixel traffic, write then read back at once.
      applyStimulus(1'b0, 2'd2, 14'h0123, 1'b1, 1'b1, 14'h0010, 16'hBEEF);
      applyStimulus(1'b0, 2'd1, 14'h0124, 1'b0, 1'b0, 14'h0000, 16'h0000);
      applyStimulus(1'b0, 2'd0, 14'h0125, 1'b1, 1'b0, 14'h0010, 16'h0000);
      repeat (3) applyStimulus(1'b0, 2'd1, 14'h0126, 1'b0, 1'b0, 14'h0000, 16'h0000);
      checkOutput("s1_wait", {16'd0, wait_cnt}, 32'd0);
      checkOutput("s2_rdata_held", {16'd0, cpu_rdata}, 32'h0000BEEF);

      // Scenario 3: request raised at phase 0 waits for phase 3.
      applyStimulus(1'b1, 2'd0, 14'h0200, 1'b1, 1'b1, 14'h0020, 16'h1234);
      applyStimulus(1'b1, 2'd1, 14'h0201, 1'b0, 1'b0, 14'h0000, 16'h0000);
      applyStimulus(1'b1, 2'd2, 14'h0202, 1'b0, 1'b0, 14'h0000, 16'h0000);
      applyStimulus(1'b1, 2'd3, 14'h0203, 1'b0, 1'b0, 14'h0000, 16'h0000);
      applyStimulus(1'b1, 2'd0, 14'h0204, 1'b0, 1'b0, 14'h0000, 16'h0000);
      applyStimulus(1'b1, 2'd1, 14'h0205, 1'b0, 1'b0, 14'h0000, 16'h0000);
      checkOutput("s3_wait", {16'd0, wait_cnt}, 32'd3);

      // Scenario 4: random phases and random host traffic on a small address window.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b1, 2'($urandom_range(0, 3)), 14'($urandom_range(0, 16383)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       14'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)));
      end
      while (hState != 0)
         applyStimulus(1'b0, 2'd0, 14'h0300, 1'b0, 1'b0, 14'h0000, 16'h0000);

      // Scenario 5: reset during RD_WAIT aborts the read; a retry then completes.
      applyStimulus(1'b0, 2'd0, 14'h0400, 1'b1, 1'b0, 14'h0010, 16'h0000);
      @(negedge clk);
      rst_n  = 1'b0;
      cpu_we = 1'b1;
      #1;
      checkOutput("s5_ack", {31'd0, cpu_ack}, 32'd0);
      checkOutput("s5_rdata", {16'd0, cpu_rdata}, 32'd0);
      checkOutput("s5_wait", {16'd0, wait_cnt}, 32'd0);
      checkOutput("s5_we", {31'd0, mem_we}, 32'd0);
      checkOutput("s5_addr", {18'd0, mem_addr}, {18'd0, px_addr});
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0, 2'd0, 14'h0401, 1'b0, 1'b0, 14'h0000, 16'h0000);
      applyStimulus(1'b0, 2'd0, 14'h0402, 1'b1, 1'b0, 14'h0010, 16'h0000);
      repeat (3) applyStimulus(1'b0, 2'd0, 14'h0403, 1'b0, 1'b0, 14'h0000, 16'h0000);

      // Scenario 6: phase stuck at 0 starves the host until the counter saturates.
      applyStimulus(1'b1, 2'd0, 14'h0500, 1'b1, 1'b0, 14'h0010, 16'h0000);
      weSeen  = 0;
      ackSeen = 0;
      addrBad = 0;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         #1;
         if (mem_we !== 1'b0) weSeen++;
         if (cpu_ack !== 1'b0) ackSeen++;
         if (mem_addr !== px_addr) addrBad++;
      end
      checkOutput("s6_wait_sat", {16'd0, wait_cnt}, 32'h0000FFFF);
      checkOutput("s6_no_write", weSeen, 32'd0);
      checkOutput("s6_no_ack", ackSeen, 32'd0);
      checkOutput("s6_px_addr", addrBad, 32'd0);
      expWait = 16'hFFFF;
      applyStimulus(1'b1, 2'd3, 14'h0501, 1'b0, 1'b0, 14'h0000, 16'h0000);
      repeat (3) applyStimulus(1'b1, 2'd0, 14'h0502, 1'b0, 1'b0, 14'h0000, 16'h0000);
      checkOutput("s6_queue_drained", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, memory word-address width; DATA_W, default 16, memory data width.
REQ-002 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 px_active  in  1  high while the pixel generator is fetching for the visible frame.
REQ-005 px_phase  in  2  pixel generator fetch phase: 0 = text fetch, 1 = glyph fetch, 2 = glyph capture, 3 = coordinate staging (memory idle).
REQ-006 px_addr  in  ADDR_W  pixel generator fetch address.
REQ-007 px_rdata  out  DATA_W  memory read data returned to the pixel generator.
REQ-008 cpu_req  in  1  host access request.
REQ-009 cpu_we  in  1  host access type: 1 = write, 0 = read.
REQ-010 cpu_addr  in  ADDR_W  host address.
REQ-011 cpu_wdata  in  DATA_W  host write data.
REQ-012 cpu_ack  out  1  one-cycle pulse signalling host access complete.
REQ-013 cpu_rdata  out  DATA_W  host read data, valid while cpu_ack=1.
REQ-014 mem_addr  out  ADDR_W  shared single-port memory address.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_rdata  in  DATA_W  memory read data, valid one cycle after its address (synchronous read).
REQ-018 wait_cnt  out  16  saturating count of cycles the host request waited without a grant.

Function
REQ-019 The pixel slot SHALL be defined as px_active=1 and px_phase!=3; in a pixel slot the block SHALL drive mem_addr=px_addr and mem_we=0, combinationally.
REQ-020 px_rdata SHALL equal mem_rdata combinationally in every cycle.
REQ-021 mem_we SHALL never be 1 during a pixel slot.
REQ-022 The FSM SHALL have the states IDLE, RD_WAIT and ACK.
REQ-023 In IDLE with cpu_req=1 and no pixel slot, the block SHALL accept: latch cpu_we, cpu_addr and cpu_wdata, and drive mem_addr=cpu_addr and mem_wdata=cpu_wdata in that same cycle (the issue cycle).
REQ-024 On an accepted write, mem_we SHALL be 1 in the issue cycle only, and the FSM SHALL go to ACK.
REQ-025 On an accepted read, mem_we SHALL be 0 and the FSM SHALL go to RD_WAIT.
REQ-026 In RD_WAIT, the block SHALL register mem_rdata into cpu_rdata and go to ACK.
REQ-027 In ACK, cpu_ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 Latency from issue cycle to cpu_ack SHALL be: write 1 cycle, read 2 cycles.
REQ-029 The host SHALL hold its request signals stable until cpu_ack; a new request SHALL NOT be accepted earlier than the cycle after cpu_ack.
REQ-030 While not in the issue cycle and no pixel slot is active, the block SHALL drive mem_addr=px_addr and mem_we=0.
REQ-031 cpu_rdata SHALL hold its value between reads; cpu_rdata SHALL be unchanged after a write.
REQ-032 wait_cnt SHALL increment by 1 in each cycle the FSM is in IDLE with cpu_req=1 and a pixel slot active.
REQ-033 wait_cnt SHALL saturate at 16'hFFFF and clear only on reset.
REQ-034 A px_active or px_phase change during RD_WAIT or ACK SHALL NOT affect the in-flight host access (the host access owns only the issue cycle).
REQ-035 cpu_req deasserted in IDLE SHALL cause no memory access.
REQ-036 cpu_req while px_active=0 SHALL be accepted in the same cycle regardless of px_phase.

Reset
REQ-037 While rst_n=0, the FSM SHALL be IDLE and the outputs SHALL be: cpu_ack=0, cpu_rdata=0, wait_cnt=0, mem_we=0; mem_addr and mem_wdata follow REQ-030.
REQ-038 Reset asserted mid-transaction SHALL abort it, with no cpu_ack and no further mem_we.
REQ-039 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-040 Scenario 1: px_active=0, write cpu_addr=14'h0010, cpu_wdata=16'hBEEF -> mem_we=1 with mem_addr=14'h0010 in the issue cycle; cpu_ack=1 one cycle later; wait_cnt=0.
REQ-041 Scenario 2: read of 14'h0010 with the memory model holding 16'hBEEF -> cpu_ack two cycles after issue, with cpu_rdata=16'hBEEF.
REQ-042 Scenario 3: px_active=1, px_phase cycling 0,1,2,3, cpu_req raised at phase 0 -> issue at phase 3; wait_cnt=3; mem_addr=px_addr in phases 0-2.
REQ-043 Scenario 4: continuous px_active=1 with random px_phase and random host traffic -> assert mem_we=0 in every pixel slot and px_rdata==mem_rdata every cycle.
REQ-044 Scenario 5: rst_n pulsed low during RD_WAIT -> no cpu_ack, cpu_rdata=0, FSM IDLE, and a retried read completes normally.
REQ-045 Scenario 6: cpu_req held with px_active=1 and px_phase stuck at 0 for 70000 cycles -> wait_cnt=16'hFFFF and no access is issued.
